// File: rtl/alu_exec_if.sv
// RS->ALU issue bus and ALU common-data-bus broadcast, bundled for the execute unit.
// The master side is the issuing RS plus the CDB arbiter; the slave side is the ALU.
interface alu_exec_if #(
  parameter int XLEN      = 32,
  parameter int ROB_IDX_W = 5,
  parameter int OP_W      = 6
) ();
  logic                 alu_enable;
  logic [OP_W-1:0]      to_alu_op;
  logic [XLEN-1:0]      to_alu_rs1_value;
  logic [XLEN-1:0]      to_alu_rs2_value;
  logic [XLEN-1:0]      to_alu_imm;
  logic [XLEN-1:0]      to_alu_pc;
  logic [ROB_IDX_W-1:0] to_alu_rd_renaming;
  logic                 cdb_grant;
  logic                 alu_full;
  logic                 alu_broadcast;
  logic [XLEN-1:0]      alu_cbd_value;
  logic [ROB_IDX_W-1:0] alu_update_rename;
  logic                 alu_is_branch;
  logic                 alu_taken;
  logic [XLEN-1:0]      alu_target_pc;

  modport master (
    output alu_enable, to_alu_op, to_alu_rs1_value, to_alu_rs2_value, to_alu_imm,
           to_alu_pc, to_alu_rd_renaming, cdb_grant,
    input  alu_full, alu_broadcast, alu_cbd_value, alu_update_rename, alu_is_branch,
           alu_taken, alu_target_pc
  );

  modport slave (
    input  alu_enable, to_alu_op, to_alu_rs1_value, to_alu_rs2_value, to_alu_imm,
           to_alu_pc, to_alu_rd_renaming, cdb_grant,
    output alu_full, alu_broadcast, alu_cbd_value, alu_update_rename, alu_is_branch,
           alu_taken, alu_target_pc
  );
endinterface

// File: rtl/alu_exec_unit.sv
// RV32I integer execute unit: computes one issued op per cycle, queues the result in a
// small FIFO and broadcasts the FIFO head on the ALU CDB until the arbiter grants it.

// Watches for an issue presented while the FIFO is full and nothing is leaving.
module alu_exec_checker (
  input logic clk,
  input logic rst,
  input logic i_rdy,
  input logic i_jump_wrong,
  input logic i_enable,
  input logic i_full,
  input logic i_pop
);
  // An issue into a full FIFO with no pop would be lost, so the RS must never do it.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst || i_jump_wrong)
    !(i_enable && i_rdy && i_full && !i_pop))
    else $error("alu_exec_unit: issue dropped, result FIFO full");
endmodule

module alu_exec_unit #(
  parameter int XLEN      = 32,
  parameter int ROB_IDX_W = 5,
  parameter int OP_W      = 6,
  parameter int RQ_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_rdy,
  input  logic        i_jump_wrong,
  alu_exec_if.slave   bus
);
  localparam int PTR_W = $clog2(RQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RQ_DEPTH);

  // Opcode encodings shared with the decoder.
  localparam logic [OP_W-1:0] OP_LUI   = OP_W'(1);
  localparam logic [OP_W-1:0] OP_AUIPC = OP_W'(2);
  localparam logic [OP_W-1:0] OP_JAL   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_JALR  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(5);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6);
  localparam logic [OP_W-1:0] OP_BLT   = OP_W'(7);
  localparam logic [OP_W-1:0] OP_BGE   = OP_W'(8);
  localparam logic [OP_W-1:0] OP_BLTU  = OP_W'(9);
  localparam logic [OP_W-1:0] OP_BGEU  = OP_W'(10);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(19);
  localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(20);
  localparam logic [OP_W-1:0] OP_SLTIU = OP_W'(21);
  localparam logic [OP_W-1:0] OP_XORI  = OP_W'(22);
  localparam logic [OP_W-1:0] OP_ORI   = OP_W'(23);
  localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(24);
  localparam logic [OP_W-1:0] OP_SLLI  = OP_W'(25);
  localparam logic [OP_W-1:0] OP_SRLI  = OP_W'(26);
  localparam logic [OP_W-1:0] OP_SRAI  = OP_W'(27);
  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(28);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(29);
  localparam logic [OP_W-1:0] OP_SLL   = OP_W'(30);
  localparam logic [OP_W-1:0] OP_SLT   = OP_W'(31);
  localparam logic [OP_W-1:0] OP_SLTU  = OP_W'(32);
  localparam logic [OP_W-1:0] OP_XOR   = OP_W'(33);
  localparam logic [OP_W-1:0] OP_SRL   = OP_W'(34);
  localparam logic [OP_W-1:0] OP_SRA   = OP_W'(35);
  localparam logic [OP_W-1:0] OP_OR    = OP_W'(36);
  localparam logic [OP_W-1:0] OP_AND   = OP_W'(37);

  // FIFO storage and control
  logic [XLEN-1:0]      r_mem_val [RQ_DEPTH];
  logic [ROB_IDX_W-1:0] r_mem_tag [RQ_DEPTH];
  logic                 r_mem_br  [RQ_DEPTH];
  logic                 r_mem_tk  [RQ_DEPTH];
  logic [XLEN-1:0]      r_mem_tgt [RQ_DEPTH];
  logic [PTR_W-1:0]     r_head, r_tail;
  logic [CNT_W-1:0]     r_count;

  // Registered head outputs
  logic                 r_bcast, r_full, r_br, r_tk;
  logic [XLEN-1:0]      r_val, r_tgt;
  logic [ROB_IDX_W-1:0] r_tag;

  logic [XLEN-1:0]      w_op2, w_pc4, w_pcimm, w_val, w_tgt;
  logic                 w_br, w_tk, w_cond_br;
  logic                 w_flush, w_pop, w_push;
  logic [PTR_W-1:0]     w_head_nxt;
  logic [CNT_W-1:0]     w_rem, w_cnt_nxt;
  logic [XLEN-1:0]      w_nh_val, w_nh_tgt;
  logic [ROB_IDX_W-1:0] w_nh_tag;
  logic                 w_nh_br, w_nh_tk;

  // I-form ops take the immediate as second operand.
  always_comb begin
    w_op2 = bus.to_alu_rs2_value;
    if ((bus.to_alu_op >= OP_ADDI) && (bus.to_alu_op <= OP_SRAI)) begin
      w_op2 = bus.to_alu_imm;
    end else begin
      w_op2 = bus.to_alu_rs2_value;
    end
  end

  // Result, branch outcome and resolved next pc for the op on the issue bus.
  always_comb begin
    w_pc4     = bus.to_alu_pc + XLEN'(4);
    w_pcimm   = bus.to_alu_pc + bus.to_alu_imm;
    w_val     = {XLEN{1'b0}};
    w_br      = 1'b0;
    w_tk      = 1'b0;
    w_cond_br = 1'b0;
    w_tgt     = w_pc4;
    case (bus.to_alu_op)
      OP_LUI:   w_val = bus.to_alu_imm;
      OP_AUIPC: w_val = w_pcimm;
      OP_JAL:   begin w_val = w_pc4; w_br = 1'b1; w_tk = 1'b1; w_tgt = w_pcimm; end
      OP_JALR:  begin
        w_val = w_pc4; w_br = 1'b1; w_tk = 1'b1;
        w_tgt = (bus.to_alu_rs1_value + bus.to_alu_imm) & ~XLEN'(1);
      end
      OP_BEQ:   begin w_cond_br = 1'b1; w_tk = (bus.to_alu_rs1_value == bus.to_alu_rs2_value); end
      OP_BNE:   begin w_cond_br = 1'b1; w_tk = (bus.to_alu_rs1_value != bus.to_alu_rs2_value); end
      OP_BLT:   begin w_cond_br = 1'b1; w_tk = ($signed(bus.to_alu_rs1_value) <  $signed(bus.to_alu_rs2_value)); end
      OP_BGE:   begin w_cond_br = 1'b1; w_tk = ($signed(bus.to_alu_rs1_value) >= $signed(bus.to_alu_rs2_value)); end
      OP_BLTU:  begin w_cond_br = 1'b1; w_tk = (bus.to_alu_rs1_value <  bus.to_alu_rs2_value); end
      OP_BGEU:  begin w_cond_br = 1'b1; w_tk = (bus.to_alu_rs1_value >= bus.to_alu_rs2_value); end
      OP_ADD, OP_ADDI:   w_val = bus.to_alu_rs1_value + w_op2;
      OP_SUB:            w_val = bus.to_alu_rs1_value - w_op2;
      OP_AND, OP_ANDI:   w_val = bus.to_alu_rs1_value & w_op2;
      OP_OR,  OP_ORI:    w_val = bus.to_alu_rs1_value | w_op2;
      OP_XOR, OP_XORI:   w_val = bus.to_alu_rs1_value ^ w_op2;
      OP_SLT, OP_SLTI:   w_val = {{(XLEN-1){1'b0}}, ($signed(bus.to_alu_rs1_value) < $signed(w_op2))};
      OP_SLTU, OP_SLTIU: w_val = {{(XLEN-1){1'b0}}, (bus.to_alu_rs1_value < w_op2)};
      OP_SLL, OP_SLLI:   w_val = bus.to_alu_rs1_value << w_op2[4:0];
      OP_SRL, OP_SRLI:   w_val = bus.to_alu_rs1_value >> w_op2[4:0];
      OP_SRA, OP_SRAI:   w_val = $signed(bus.to_alu_rs1_value) >>> w_op2[4:0];
      default:           w_val = {XLEN{1'b0}};
    endcase
    if (w_cond_br) begin
      w_br  = 1'b1;
      w_val = {{(XLEN-1){1'b0}}, w_tk};
      w_tgt = w_tk ? w_pcimm : w_pc4;
    end else begin
      w_br  = w_br;
    end
  end

  // FIFO handshake: flush beats everything, rdy gates both push and pop.
  always_comb begin
    w_flush    = rst || i_jump_wrong;
    w_pop      = r_bcast && bus.cdb_grant && i_rdy;
    w_push     = bus.alu_enable && i_rdy && !w_flush && ((r_count < DEPTH_C) || w_pop);
    w_head_nxt = w_pop ? (r_head + PTR_W'(1)) : r_head;
    w_rem      = r_count - CNT_W'(w_pop);
    w_cnt_nxt  = w_rem + CNT_W'(w_push);
  end

  // Head contents after this edge; bypass the fresh result when it lands at an empty head.
  always_comb begin
    w_nh_val = {XLEN{1'b0}};
    w_nh_tag = {ROB_IDX_W{1'b0}};
    w_nh_br  = 1'b0;
    w_nh_tk  = 1'b0;
    w_nh_tgt = {XLEN{1'b0}};
    if (w_cnt_nxt == {CNT_W{1'b0}}) begin
      w_nh_val = {XLEN{1'b0}};
    end else if (w_rem == {CNT_W{1'b0}}) begin
      w_nh_val = w_val;
      w_nh_tag = bus.to_alu_rd_renaming;
      w_nh_br  = w_br;
      w_nh_tk  = w_tk;
      w_nh_tgt = w_tgt;
    end else begin
      w_nh_val = r_mem_val[w_head_nxt];
      w_nh_tag = r_mem_tag[w_head_nxt];
      w_nh_br  = r_mem_br[w_head_nxt];
      w_nh_tk  = r_mem_tk[w_head_nxt];
      w_nh_tgt = r_mem_tgt[w_head_nxt];
    end
  end

  // Result storage write at the tail.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_val[r_tail] <= w_val;
      r_mem_tag[r_tail] <= bus.to_alu_rd_renaming;
      r_mem_br[r_tail]  <= w_br;
      r_mem_tk[r_tail]  <= w_tk;
      r_mem_tgt[r_tail] <= w_tgt;
    end
  end

  // Pointers, occupancy and registered head outputs; frozen while rdy is low.
  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_head  <= {PTR_W{1'b0}};
      r_tail  <= {PTR_W{1'b0}};
      r_count <= {CNT_W{1'b0}};
      r_bcast <= 1'b0;
      r_full  <= 1'b0;
      r_val   <= {XLEN{1'b0}};
      r_tag   <= {ROB_IDX_W{1'b0}};
      r_br    <= 1'b0;
      r_tk    <= 1'b0;
      r_tgt   <= {XLEN{1'b0}};
    end else if (i_rdy) begin
      r_head  <= w_head_nxt;
      r_tail  <= w_push ? (r_tail + PTR_W'(1)) : r_tail;
      r_count <= w_cnt_nxt;
      r_bcast <= (w_cnt_nxt != {CNT_W{1'b0}});
      r_full  <= (w_cnt_nxt == DEPTH_C);
      r_val   <= w_nh_val;
      r_tag   <= w_nh_tag;
      r_br    <= w_nh_br;
      r_tk    <= w_nh_tk;
      r_tgt   <= w_nh_tgt;
    end
  end

  assign bus.alu_full          = r_full;
  assign bus.alu_broadcast     = r_bcast;
  assign bus.alu_cbd_value     = r_val;
  assign bus.alu_update_rename = r_tag;
  assign bus.alu_is_branch     = r_br;
  assign bus.alu_taken         = r_tk;
  assign bus.alu_target_pc     = r_tgt;

  alu_exec_checker u_checker (
    .clk          (clk),
    .rst          (rst),
    .i_rdy        (i_rdy),
    .i_jump_wrong (i_jump_wrong),
    .i_enable     (bus.alu_enable),
    .i_full       (r_full),
    .i_pop        (w_pop)
  );
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit with an expected-result queue and an ISA reference model.
module tb_alu_exec_unit;
  localparam int D = 4;

  localparam logic [5:0] LUI = 6'd1, AUIPC = 6'd2, JAL = 6'd3, JALR = 6'd4;
  localparam logic [5:0] BEQ = 6'd5, BNE = 6'd6, BLT = 6'd7, BGE = 6'd8, BLTU = 6'd9, BGEU = 6'd10;
  localparam logic [5:0] ADDI = 6'd19, SLTI = 6'd20, SLTIU = 6'd21, XORI = 6'd22, ORI = 6'd23;
  localparam logic [5:0] ANDI = 6'd24, SLLI = 6'd25, SRLI = 6'd26, SRAI = 6'd27;
  localparam logic [5:0] ADD = 6'd28, SUB = 6'd29, SLL = 6'd30, SLT = 6'd31, SLTU = 6'd32;
  localparam logic [5:0] XOR = 6'd33, SRL = 6'd34, SRA = 6'd35, OR = 6'd36, AND = 6'd37;

  typedef struct packed {
    logic [31:0] val;
    logic [4:0]  tag;
    logic        br;
    logic        tk;
    logic [31:0] tgt;
  } exp_t;

  logic clk = 1'b0;
  logic rst, rdy, jw;
  exp_t q[$];
  int   mc;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   after_flush;

  alu_exec_if #(.XLEN(32), .ROB_IDX_W(5), .OP_W(6)) bus ();

  alu_exec_unit #(.XLEN(32), .ROB_IDX_W(5), .OP_W(6), .RQ_DEPTH(D)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_rdy        (rdy),
    .i_jump_wrong (jw),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(logic [5:0] op, logic [31:0] a, logic [31:0] b,
                                 logic [31:0] imm, logic [31:0] pc, logic [4:0] tag);
    exp_t m;
    logic [31:0] o2;
    logic c;
    m.val = 32'd0; m.tag = tag; m.br = 1'b0; m.tk = 1'b0; m.tgt = pc + 32'd4;
    o2 = (op >= ADDI && op <= SRAI) ? imm : b;
    c = 1'b0;
    case (op)
      LUI:   m.val = imm;
      AUIPC: m.val = pc + imm;
      JAL:   begin m.val = pc + 32'd4; m.br = 1'b1; m.tk = 1'b1; m.tgt = pc + imm; end
      JALR:  begin m.val = pc + 32'd4; m.br = 1'b1; m.tk = 1'b1; m.tgt = (a + imm) & 32'hFFFF_FFFE; end
      BEQ, BNE, BLT, BGE, BLTU, BGEU: begin
        case (op)
          BEQ:  c = (a == b);
          BNE:  c = (a != b);
          BLT:  c = ($signed(a) < $signed(b));
          BGE:  c = !($signed(a) < $signed(b));
          BLTU: c = (a < b);
          default: c = !(a < b);
        endcase
        m.br = 1'b1; m.tk = c; m.val = {31'd0, c}; m.tgt = c ? pc + imm : pc + 32'd4;
      end
      ADD, ADDI:   m.val = a + o2;
      SUB:         m.val = a - o2;
      AND, ANDI:   m.val = a & o2;
      OR, ORI:     m.val = a | o2;
      XOR, XORI:   m.val = a ^ o2;
      SLT, SLTI:   m.val = ($signed(a) < $signed(o2)) ? 32'd1 : 32'd0;
      SLTU, SLTIU: m.val = (a < o2) ? 32'd1 : 32'd0;
      SLL, SLLI:   m.val = a << o2[4:0];
      SRL, SRLI:   m.val = a >> o2[4:0];
      SRA, SRAI:   m.val = 32'($signed(a) >>> o2[4:0]);
      default:     m.val = 32'd0;
    endcase
    return m;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic drive(logic en, logic [5:0] op, logic [31:0] a, logic [31:0] b,
                       logic [31:0] imm, logic [31:0] pc, logic [4:0] tag);
    bus.alu_enable = en; bus.to_alu_op = op; bus.to_alu_rs1_value = a;
    bus.to_alu_rs2_value = b; bus.to_alu_imm = imm; bus.to_alu_pc = pc;
    bus.to_alu_rd_renaming = tag;
  endtask

  // Check current outputs against the scoreboard, predict this edge, then advance one cycle.
  task automatic tick();
    bit pop_e, push_e;
    exp_t h;
    chk("broadcast", {31'd0, bus.alu_broadcast}, {31'd0, (mc != 0)});
    chk("full", {31'd0, bus.alu_full}, {31'd0, (mc == D)});
    if (mc != 0) begin
      h = q[0];
      chk("value", bus.alu_cbd_value, h.val);
      chk("rename", {27'd0, bus.alu_update_rename}, {27'd0, h.tag});
      chk("is_branch", {31'd0, bus.alu_is_branch}, {31'd0, h.br});
      chk("taken", {31'd0, bus.alu_taken}, {31'd0, h.tk});
      chk("target", bus.alu_target_pc, h.tgt);
    end else if (after_flush) begin
      chk("flush_value", bus.alu_cbd_value, 32'd0);
      chk("flush_target", bus.alu_target_pc, 32'd0);
    end else begin
      after_flush = after_flush;
    end
    after_flush = 1'b0;
    if (rst || jw) begin
      q.delete(); mc = 0; after_flush = 1'b1;
    end else if (rdy) begin
      pop_e  = (mc != 0) && bus.cdb_grant;
      push_e = bus.alu_enable && ((mc < D) || pop_e);
      if (pop_e) void'(q.pop_front());
      if (push_e) q.push_back(model(bus.to_alu_op, bus.to_alu_rs1_value, bus.to_alu_rs2_value,
                                    bus.to_alu_imm, bus.to_alu_pc, bus.to_alu_rd_renaming));
      mc = mc + int'(push_e) - int'(pop_e);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; jw = 1'b0; bus.cdb_grant = 1'b0; mc = 0; after_flush = 1'b0;
    drive(1'b0, 6'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0);
    @(posedge clk); #1; @(posedge clk); #1;
    chk("rst_broadcast", {31'd0, bus.alu_broadcast}, 32'd0);
    chk("rst_full", {31'd0, bus.alu_full}, 32'd0);
    chk("rst_value", bus.alu_cbd_value, 32'd0);
    chk("rst_target", bus.alu_target_pc, 32'd0);
    rst = 1'b0;

    // ADD, one-cycle broadcast under grant
    bus.cdb_grant = 1'b1;
    drive(1'b1, ADD, 32'd5, 32'd7, 32'd0, 32'h40, 5'd3); tick();
    drive(1'b0, ADD, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0);
    chk("t1_value", bus.alu_cbd_value, 32'd12);
    chk("t1_rename", {27'd0, bus.alu_update_rename}, 32'd3);
    tick(); tick();

    // signed vs unsigned compare branch
    drive(1'b1, BLT, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 5'd1); tick();
    chk("t2_blt_target", bus.alu_target_pc, 32'h120);
    drive(1'b1, BLTU, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 5'd2); tick();
    chk("t2_bltu_target", bus.alu_target_pc, 32'h104);
    drive(1'b1, JALR, 32'h1003, 32'd0, 32'd4, 32'h200, 5'd7); tick();
    chk("t3_jalr_target", bus.alu_target_pc, 32'h1006);
    chk("t3_jalr_value", bus.alu_cbd_value, 32'h204);
    drive(1'b0, ADD, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0); tick();

    // remaining op classes, including shift-amount masking and an unknown opcode
    drive(1'b1, LUI,   32'd0, 32'd0, 32'hABCD_E000, 32'h0, 5'd4); tick();
    drive(1'b1, AUIPC, 32'd0, 32'd0, 32'h0000_1000, 32'h300, 5'd5); tick();
    drive(1'b1, JAL,   32'd0, 32'd0, 32'hFFFF_FFF0, 32'h400, 5'd6); tick();
    drive(1'b1, SRA,   32'h8000_0010, 32'h0000_0124, 32'd0, 32'h0, 5'd8); tick();
    drive(1'b1, SRAI,  32'hF000_0000, 32'd0, 32'd4, 32'h0, 5'd9); tick();
    drive(1'b1, SUB,   32'd3, 32'd5, 32'd0, 32'h0, 5'd10); tick();
    drive(1'b1, SLT,   32'hFFFF_FFFE, 32'd1, 32'd0, 32'h0, 5'd11); tick();
    drive(1'b1, SLTIU, 32'd1, 32'd0, 32'hFFFF_FFFF, 32'h0, 5'd12); tick();
    drive(1'b1, BGE,   32'd1, 32'd1, 32'h8, 32'h500, 5'd13); tick();
    drive(1'b1, BNE,   32'd1, 32'd1, 32'h8, 32'h500, 5'd14); tick();
    drive(1'b1, 6'd63, 32'd9, 32'd9, 32'd9, 32'h600, 5'd15); tick();
    drive(1'b0, ADD, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0); tick(); tick();

    // fill to full with grant low, hold, then drain with an issue riding a pop
    bus.cdb_grant = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, ADDI, 32'(i * 100), 32'd0, 32'(i), 32'h0, 5'(i)); tick();
    end
    drive(1'b0, ADD, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0);
    chk("t4_full", {31'd0, bus.alu_full}, 32'd1);
    tick(); tick();
    chk("t4_head_held", {27'd0, bus.alu_update_rename}, 32'd1);
    bus.cdb_grant = 1'b1;
    drive(1'b1, XORI, 32'h55, 32'd0, 32'hFF, 32'h0, 5'd5); tick();
    drive(1'b0, ADD, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0);
    for (int i = 0; i < 6; i++) tick();

    // flush with three entries queued and an issue in the same cycle
    bus.cdb_grant = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, OR, 32'(i), 32'h10, 32'd0, 32'h0, 5'(20 + i)); tick();
    end
    jw = 1'b1;
    drive(1'b1, AND, 32'hF, 32'h3, 32'd0, 32'h0, 5'd30); tick();
    jw = 1'b0;
    drive(1'b0, ADD, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0);
    chk("t5_broadcast", {31'd0, bus.alu_broadcast}, 32'd0);
    chk("t5_full", {31'd0, bus.alu_full}, 32'd0);
    tick();

    // rdy low freezes everything, then resumes
    drive(1'b1, SLL, 32'd1, 32'd31, 32'd0, 32'h0, 5'd24); tick();
    drive(1'b1, SRL, 32'h8000_0000, 32'd33, 32'd0, 32'h0, 5'd25); tick();
    rdy = 1'b0; bus.cdb_grant = 1'b1;
    drive(1'b1, ADD, 32'd1, 32'd1, 32'd0, 32'h0, 5'd26);
    for (int i = 0; i < 3; i++) tick();
    chk("t6_head_frozen", {27'd0, bus.alu_update_rename}, 32'd24);
    rdy = 1'b1;
    drive(1'b0, ADD, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0);
    for (int i = 0; i < 3; i++) tick();

    // random traffic with random grant, never issuing into a full FIFO without a pop
    for (int i = 0; i < 60; i++) begin
      bus.cdb_grant = 1'($urandom_range(0, 1));
      drive(1'($urandom_range(0, 1)), 6'($urandom_range(1, 37)), $urandom, $urandom,
            $urandom, $urandom & 32'hFFFF_FFFC, 5'($urandom_range(0, 31)));
      if (mc == D && !bus.cdb_grant) bus.alu_enable = 1'b0;
      tick();
    end
    bus.cdb_grant = 1'b1;
    drive(1'b0, ADD, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0);
    for (int i = 0; i < 6; i++) tick();
    chk("drained", mc, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
